// File: rtl/div_arbiter.sv
// div_arbiter: round-robin scheduler sharing one sequential 32-bit divider
// among N requesters. One request in flight at a time; divide-by-zero is
// answered directly with a saturated quotient and never reaches the divider.
module div_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [N-1:0]      req_valid,
  input  logic [N*32-1:0]   req_dividend,
  input  logic [N*32-1:0]   req_divisor,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      resp_valid,
  output logic [31:0]       resp_quotient,
  output logic [31:0]       resp_remainder,
  output logic              resp_err,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              div_en,
  output logic              div_start,
  output logic [31:0]       div_dividend,
  output logic [31:0]       div_divisor,
  input  logic              div_done,
  input  logic [31:0]       div_quotient,
  input  logic [31:0]       div_remainder
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, ZERO} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  grant_id_q;
  logic [31:0]     dividend_q;
  logic [31:0]     divisor_q;
  logic [31:0]     quot_q;
  logic [31:0]     rem_q;
  logic            err_q;
  logic [N-1:0]    resp_pulse_q;

  // Per-slot views of the packed operand buses and the candidate search order
  logic [31:0]     slot_dividend [N];
  logic [31:0]     slot_divisor  [N];
  logic [IDW-1:0]  cand          [N];
  logic [IDW-1:0]  cand_next     [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign slot_dividend[gi] = req_dividend[32*gi +: 32];
      assign slot_divisor[gi]  = req_divisor[32*gi +: 32];
      assign cand[gi]          = IDW'((int'(rr_q) + gi) % N);
      assign cand_next[gi]     = IDW'((int'(rr_q) + gi + 1) % N);
    end
  endgenerate

  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  pick_next;

  // Round-robin search: scan from the highest offset down so the candidate
  // closest to the rr pointer is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_next  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        pick_found = 1'b1;
        pick_id    = cand[k];
        pick_next  = cand_next[k];
      end
    end
  end

  // Scheduler FSM: accept, issue, wait for the divider, and return the result
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      grant_id_q   <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      resp_pulse_q <= '0;
    end else if (en) begin
      resp_pulse_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q <= pick_id;
            rr_q       <= pick_next;
            dividend_q <= slot_dividend[pick_id];
            divisor_q  <= slot_divisor[pick_id];
            state_q    <= (slot_divisor[pick_id][30:0] == 31'd0) ? ZERO : ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (div_done) state_q <= CAPTURE;
        end
        CAPTURE: begin
          quot_q       <= div_quotient;
          rem_q        <= div_remainder;
          err_q        <= 1'b0;
          resp_pulse_q <= N'(1) << grant_id_q;
          state_q      <= IDLE;
        end
        ZERO: begin
          quot_q       <= {dividend_q[31] ^ divisor_q[31], 31'h7FFF_FFFF};
          rem_q        <= '0;
          err_q        <= 1'b1;
          resp_pulse_q <= N'(1) << grant_id_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept strobe is also held off while reset is asserted so no request is
  // consumed by a block that is being cleared.
  assign req_ready      = (state_q == IDLE && pick_found && en && nrst) ? (N'(1) << pick_id) : '0;
  assign resp_valid     = resp_pulse_q & {N{en}};
  assign resp_quotient  = quot_q;
  assign resp_remainder = rem_q;
  assign resp_err       = err_q;
  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_id_q;
  assign div_en         = en;
  assign div_start      = (state_q == ISSUE) && en;
  assign div_dividend   = dividend_q;
  assign div_divisor    = divisor_q;

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin scheduler that shares one 32-bit sequential divider among N requesters, e.g. the PID, attitude and mixer stages that each need occasional divides.
- Owns the divider's start/en/operand pins and accepts one request at a time over a valid/ready handshake.
- Waits for the divider's done pulse and returns quotient/remainder to the originating requester with a one-cycle response pulse.
- Short-circuits divide-by-zero without using the divider.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, $clog2(N), width of grant/response id.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  global clock enable; low freezes the block and the divider
- req_valid  in  N  per-requester request
- req_dividend  in  N*32  packed operands, slot i = bits [32i+31:32i]; sign-magnitude (bit31 sign, [30:0] magnitude)
- req_divisor  in  N*32  packed, same format
- req_ready  out  N  one-hot accept strobe
- resp_valid  out  N  one-hot response strobe
- resp_quotient  out  32  result, sign-magnitude
- resp_remainder  out  32  remainder, non-negative magnitude
- resp_err  out  1  divide-by-zero flag, qualified by resp_valid
- busy  out  1  high whenever state != IDLE
- grant_id  out  IDW  id of request in flight
- div_en  out  1  divider enable, equals en
- div_start  out  1  divider start strobe
- div_dividend  out  32  latched dividend
- div_divisor  out  32  latched divisor
- div_done  in  1  divider done pulse
- div_quotient  in  32  divider quotient; valid the cycle after div_done
- div_remainder  in  32  divider remainder; valid the cycle after div_done

Behaviour:
- Reset values: state IDLE, rr pointer 0, grant_id 0, all resp registers 0, resp_err 0, latched operands 0. Every strobe output is 0.
- All registers update only when en=1. req_ready, resp_valid and div_start are ANDed with en.
- States: IDLE, ISSUE, WAIT, CAPTURE, ZERO.
- IDLE:
  - Pick the first i with req_valid[i]=1, searching from the rr pointer upward mod N.
  - In that cycle assert req_ready[i] and latch operands and i into grant_id; set rr pointer = (i+1) mod N.
  - If divisor[30:0]==0, go to ZERO; otherwise go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: div_start=1 for exactly one cycle; go to WAIT.
- WAIT: hold operands stable on div_dividend/div_divisor; go to CAPTURE on the cycle div_done=1.
- CAPTURE:
  - Load resp_quotient/resp_remainder from div_quotient/div_remainder and set resp_err=0.
  - Set resp pulse register for grant_id; go to IDLE.
- ZERO:
  - Load resp_quotient = {dividend[31]^divisor[31], 31'h7FFF_FFFF} (signed saturation), resp_remainder=0, resp_err=1.
  - Set resp pulse register; go to IDLE.
- resp_valid[grant_id] is high for exactly one enabled cycle, the cycle after CAPTURE/ZERO.
- resp data holds until the next response.
- IDLE may accept a new request in the same cycle resp_valid is high.
- Requesters hold req_valid and operands stable until req_ready. Dropping req_valid before ready withdraws the request; the rr pointer is unchanged.
- Only one request is in flight; other requesters wait with req_ready=0.
- div_done seen outside WAIT is ignored.
- Reset mid-operation: immediate return to reset values. No response is issued for the in-flight request; the divider is reset by the same nrst.
- Latency (nonzero divisor): accept cycle → ISSUE +1 → divider time → CAPTURE (cycle after div_done) → resp_valid +1.
- Zero divisor: resp_valid 2 cycles after accept.

Test Plan:
- Single request, slot 0: dividend 0x0000_0064, divisor 0x0000_0007 → req_ready[0] one cycle, one div_start pulse, resp_valid[0] one cycle after CAPTURE, quotient 0x0000_000E, remainder 2, err 0.
- Sign: slot 2, dividend 0x8000_0064, divisor 0x0000_0007 → quotient 0x8000_000E, remainder 2, resp_valid[2] only.
- Slots 1 and 3 assert together from reset → slot 1 served first, slot 3 accepted in the cycle resp_valid[1] is high. Continuous requests on all 4 slots → grant order 0,1,2,3,0.
- Divide-by-zero: slot 1, dividend 0x8000_0005, divisor 0x8000_0000 → no div_start, resp_valid[1] 2 cycles after accept, quotient 0x7FFF_FFFF, remainder 0, err 1.
- en held low 10 cycles during WAIT → state, operands and div_en frozen, no strobes. Result matches the un-stalled run, delayed by 10 cycles.
- nrst pulsed low during WAIT → busy=0, all strobes 0 immediately, no resp_valid. A following request completes normally.
